// File: rtl/int_to_fp_arb.sv
// Iterative 8-bit signed int to 13-bit fp converter
// shared by two requesters with round-robin grant.
module int_to_fp_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  int0,
  input  logic        req1,
  input  logic [7:0]  int1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic        done_tick,
  output logic        done_id,
  output logic [12:0] fp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  mag_q, mag_d;
  logic [3:0]  exp_q, exp_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [12:0] fp_q, fp_d;
  logic        done_id_q, done_id_d;

  logic        g0, g1;
  logic [7:0]  opnd;

  // Round-robin pick: on a tie, serve the one not served last.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      g0 = req0 & (~req1 | last_q);
      g1 = req1 & (~req0 | ~last_q);
    end
    opnd = g1 ? int1 : int0;
  end

  // Next-state: capture on grant, shift-normalize, publish result.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    id_d      = id_q;
    last_d    = last_q;
    fp_d      = fp_q;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (g0 || g1) begin
          sign_d  = opnd[7];
          mag_d   = opnd[7] ? (~opnd + 8'd1) : opnd;
          exp_d   = 4'd8;
          id_d    = g1;
          last_d  = g1;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mag_q == 8'd0) begin
          sign_d    = 1'b0;
          exp_d     = 4'd0;
          fp_d      = 13'd0;
          done_id_d = id_q;
          state_d   = S_DONE;
        end else if (mag_q[7]) begin
          fp_d      = {sign_q, exp_q, mag_q};
          done_id_d = id_q;
          state_d   = S_DONE;
        end else begin
          mag_d = {mag_q[6:0], 1'b0};
          exp_d = exp_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= 8'd0;
      exp_q     <= 4'd0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      fp_q      <= 13'd0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      id_q      <= id_d;
      last_q    <= last_d;
      fp_q      <= fp_d;
      done_id_q <= done_id_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ack0      = g0;
    ack1      = g1;
    busy      = (state_q != S_IDLE);
    done_tick = (state_q == S_DONE);
    done_id   = done_id_q;
    fp        = fp_q;
  end

endmodule

// File: tb/tb_int_to_fp_arb.sv
// Scoreboard bench for int_to_fp_arb: arbitration
// model, arithmetic fp reference, latency and hold checks.
module tb_int_to_fp_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [7:0]  int0 = 8'd0;
  logic [7:0]  int1 = 8'd0;
  logic        ack0, ack1, busy, done_tick, done_id;
  logic [12:0] fp;

  always #5 clk = ~clk;

  int_to_fp_arb dut (
    .clk(clk), .reset(reset),
    .req0(req0), .int0(int0),
    .req1(req1), .int1(int1),
    .ack0(ack0), .ack1(ack1),
    .busy(busy), .done_tick(done_tick),
    .done_id(done_id), .fp(fp)
  );

  typedef struct {
    int          id;
    logic [12:0] fp;
    int          lat;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  int          order[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          m_last = 1;
  logic [12:0] hold_fp = '0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: value = 0.frac * 2^exp with the top frac bit set.
  function automatic void model(input logic [7:0] x,
                                output logic [12:0] f,
                                output int lat);
    int v, m, e;
    v = int'($signed(x));
    m = (v < 0) ? -v : v;
    if (m == 0) begin
      f = 13'd0;
      lat = 2;
    end else begin
      e = 0;
      while ((1 << e) <= m) e++;
      f = {(v < 0), 4'(e), 8'(m << (8 - e))};
      lat = (8 - e) + 2;
    end
  endfunction

  // Monitor: predicts grants, pushes expectations, checks results.
  always @(negedge clk) begin
    bit          free, e0, e1;
    exp_t        e;
    logic [12:0] mf;
    int          ml;
    cyc++;
    if (reset) begin
      sb.delete();
      m_last = 1;
      hold_fp = '0;
      chk("rst_fp", int'(fp), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done_tick), 0);
      chk("rst_ack", int'({ack1, ack0}), 0);
      chk("rst_id", int'(done_id), 0);
    end else begin
      free = (sb.size() == 0);
      e0 = free && req0 && (!req1 || m_last == 1);
      e1 = free && req1 && (!req0 || m_last == 0);
      chk("busy", int'(busy), int'(!free));
      if (ack0 || ack1 || e0 || e1) begin
        chk("ack0", int'(ack0), int'(e0));
        chk("ack1", int'(ack1), int'(e1));
        chk("ack_excl", int'(ack0 & ack1), 0);
      end
      if (e0 || e1) begin
        model(e1 ? int1 : int0, mf, ml);
        e.id = e1 ? 1 : 0;
        e.fp = mf;
        e.lat = ml;
        e.gcyc = cyc;
        sb.push_back(e);
        m_last = e.id;
        order.push_back(e.id);
      end
      if (done_tick) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexp: got done_tick expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("fp", int'(fp), int'(e.fp));
          chk("done_id", int'(done_id), e.id);
          chk("latency", cyc - e.gcyc, e.lat);
          hold_fp = e.fp;
        end
      end else begin
        chk("fp_hold", int'(fp), int'(hold_fp));
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] v);
    int t = 0;
    if (id == 0) begin req0 = 1'b1; int0 = v; end
    else begin req1 = 1'b1; int1 = v; end
    do begin
      @(negedge clk);
      t++;
    end while (!(id == 0 ? ack0 : ack1) && t < 300);
    if (t >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL req%0d_timeout: got no ack expected ack", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sb.size() != 0 || busy) && t < 300);
    if (t >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_user(input int id, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      if (busy && ($urandom_range(0, 3) == 0)) begin
        if (id == 0) req0 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      case ($urandom_range(0, 5))
        0: v = 8'h00;
        1: v = 8'h80;
        default: v = 8'($urandom);
      endcase
      issue(id, v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    issue(0, 8'h05);
    wait_idle();
    issue(1, 8'hFD);
    wait_idle();
    issue(0, 8'h7F);
    wait_idle();
    issue(1, 8'h80);
    wait_idle();
    issue(0, 8'h01);
    wait_idle();
    issue(1, 8'h00);
    wait_idle();

    do_reset();
    order.delete();
    fork
      begin issue(0, 8'h11); issue(0, 8'hE0); end
      begin issue(1, 8'h3C); issue(1, 8'hFF); end
    join
    wait_idle();
    chk("tie_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("tie_g0", order[0], 0);
      chk("tie_g1", order[1], 1);
      chk("tie_g2", order[2], 0);
      chk("tie_g3", order[3], 1);
    end

    issue(1, 8'h01);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    order.delete();
    fork
      issue(0, 8'h22);
      issue(1, 8'h9A);
    join
    wait_idle();
    chk("rst_tie_count", order.size(), 2);
    if (order.size() == 2) chk("rst_tie_first", order[0], 0);

    fork
      issue(0, 8'h01);
      begin
        repeat (3) @(posedge clk);
        #1;
        issue(1, 8'h40);
      end
    join
    wait_idle();

    fork
      rand_user(0, 25);
      rand_user(1, 25);
    join
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_fp_arb.md
Name: int_to_fp_arb

Overview:
- Iterative signed-integer to floating-point converter shared between two requesters under round-robin arbitration.
- Shifts the magnitude left one bit per clock until normalized, instead of using a priority encoder.
- Output uses the team's 13-bit format: {sign, exp[3:0], frac[7:0]}, where value = 0.frac × 2^exp and frac[7] = 1 for nonzero values.
- Sits between two producers of 8-bit two's-complement samples and the downstream FP datapath.

Parameters:
- None. Widths are fixed by the 8-bit integer and 13-bit fp formats.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 has an operand; held high until ack0.
- int0  in  8  requester 0 operand, two's complement; valid while req0 = 1.
- req1  in  1  requester 1 has an operand; held high until ack1.
- int1  in  8  requester 1 operand, two's complement.
- ack0  out  1  one-cycle grant to requester 0; its operand is captured at this clock edge.
- ack1  out  1  one-cycle grant to requester 1.
- busy  out  1  high whenever the state is not idle.
- done_tick  out  1  one-cycle pulse; fp and done_id are valid in this cycle.
- done_id  out  1  requester that owns the current fp result.
- fp  out  13  registered result; holds its value until the next done_tick.

Behaviour:
- Reset (async): state = idle; fp = 0; done_id = 0; done_tick = 0; ack0/ack1 = 0; busy = 0; last-served pointer = 1, so req0 wins the first tie.
- States:
  - idle:
    - No req: stay in idle.
    - Exactly one req: grant it.
    - Both reqs: grant the requester other than last-served.
    - Grant actions:
      - ackN is a combinational (Mealy) output, asserted in idle in the same cycle as the grant.
      - At the edge: sign_r = intN[7]; mag_r (8-bit) = intN[7] ? (~intN + 1) : intN; exp_r = 8; id_r = N; last-served = N.
      - Next state: norm.
  - norm: one evaluation per cycle.
    - mag_r == 0: sign_r = 0 (no negative zero), exp_r = 0; go to done.
    - mag_r[7] == 1: go to done.
    - Else: mag_r <<= 1, exp_r -= 1; stay in norm.
  - done:
    - done_tick = 1; fp = {sign_r, exp_r, mag_r}; done_id = id_r.
    - fp is loaded on entry to done so it is valid during done_tick.
    - Next state: idle.
- Magnitude is 8 bits, so -128 converts exactly: sign 1, exp 8, frac 1000_0000. There is no overflow case.
- Latency, counted from the grant edge to the done_tick cycle:
  - Nonzero operand: lz + 2 cycles, where lz = leading zeros of the 8-bit magnitude.
  - Zero operand: 2 cycles.
  - Range: 2 to 9 cycles.
- No grants are issued while busy. Requests wait with req held; ack0 and ack1 are never high together.
- Back-to-back operation: the earliest next grant is the idle cycle following done. Minimum spacing between grants is 3 cycles.
- Dropping req before ack means the request is withdrawn with no side effects.
- Reset mid-conversion: abort immediately. No done_tick; fp = 0; the pointer returns to 1.
- busy = 1 in norm and done; busy = 0 in idle, including the ack cycle.

Test Plan:
- Reset, then req0 with int0 = 8'h05:
  - ack0 in the same cycle.
  - done_tick 7 cycles after the grant edge (lz = 5).
  - fp = 13'h03A0, done_id = 0.
- req1 with int1 = 8'hFD (-3) -> fp = 13'h12C0, done_id = 1, latency 8.
- Extremes:
  - int = 8'h7F -> fp = 13'h07FE, latency 3.
  - int = 8'h80 -> fp = 13'h1880, latency 2.
  - int = 8'h01 -> fp = 13'h0180, latency 9.
  - int = 8'h00 -> fp = 13'h0000, latency 2.
- req0 and req1 held together continuously after reset:
  - Grant order is 0, 1, 0, 1.
  - Each done_id matches its grant.
  - ack pulses are never concurrent.
  - No grant occurs while busy = 1.
- Assert reset during norm (int = 8'h01, 3 cycles after grant):
  - fp = 0, busy = 0, no done_tick.
  - A subsequent tie is won by req0.
- req1 arrives while busy -> ack1 waits until the idle cycle after done_tick; the fp from the prior conversion holds until the new done_tick.
